// File: rtl/mux_pipe_stage.sv
// N-way channel select feeding a registered output stage with valid/ready handshake.
// A one-entry skid register absorbs the accept that lands while the output is stalled.
module mux_pipe_stage #(
   parameter  int WIDTH = 5,
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic             sel_ok;
   logic [WIDTH-1:0] sel_data;
   logic             accept;

   logic [WIDTH-1:0] main_data;
   logic             main_err;
   logic             main_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic             skid_valid;

   // With a power-of-two channel count every select code is legal.
   if (N == (1 << SEL_W)) begin : g_pow2
      assign sel_ok = 1'b1;
   end else begin : g_npow2
      assign sel_ok = (32'(in_sel) < N);
   end

   // No channel matches an illegal select, so the data falls through as zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (32'(in_sel) == i) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = rst_n & ~skid_valid;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_err   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_err   <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || out_ready) begin
         if (skid_valid) begin
            main_data  <= skid_data;
            main_err   <= skid_err;
            main_valid <= 1'b1;
            skid_valid <= accept;
            if (accept) begin
               skid_data <= sel_data;
               skid_err  <= ~sel_ok;
            end
         end else if (accept) begin
            main_data  <= sel_data;
            main_err   <= ~sel_ok;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_data  <= sel_data;
         skid_err   <= ~sel_ok;
         skid_valid <= 1'b1;
      end
   end

   assign out_data  = main_data;
   assign out_err   = main_err;
   assign out_valid = main_valid;

endmodule
